alu_exec_unit: RTL

- Parametrised successor to the combinational ALU control decoder.
- Decodes {ctrl, funct} as before and also executes the operation.
- Adds HI/LO registers, iterative multiply/divide and a start/busy/done handshake, so the multi-cycle sequence controller can stall on long operations.
- Sits between the register-file operand latches (A/B) and ALUOut in the datapath.

---
 rtl/alu_exec_unit.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// ALU execute unit. It decodes {ctrl, funct} and runs single-cycle operations
// with a one-cycle latency. Multiply and divide run iteratively and own the
// HI/LO pair. A start/busy/done handshake lets the sequencer stall while a
// long operation is in progress.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         ctrl,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  state_t state, state_nxt;

  // Absolute value when the operation is signed; otherwise pass through.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  // Restores the sign of a quotient or remainder after magnitude division.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  // Restores the sign of a double-width product.
  function automatic logic [2*WIDTH-1:0] apply_sign2(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
    return neg ? -v : v;
  endfunction

  logic signed [WIDTH-1:0] sa, sb;
  logic [SHAMT_W-1:0]      vamt;

  assign sa   = src_a;
  assign sb   = src_b;
  assign vamt = src_a[SHAMT_W-1:0];

  logic [WIDTH-1:0] sc_res;
  logic             sc_ill, go_mul, go_div, md_signed, wr_hi, wr_lo;

  // Operation decode and single-cycle result.
  always_comb begin
    sc_res    = '0;
    sc_ill    = 1'b0;
    go_mul    = 1'b0;
    go_div    = 1'b0;
    md_signed = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (ctrl)
      3'b000:  sc_res = src_a + src_b;
      3'b001:  sc_res = src_a - src_b;
      3'b011:  sc_res = WIDTH'(sa < sb);
      3'b100:  sc_res = src_a & src_b;
      3'b101:  sc_res = src_a | src_b;
      3'b110:  sc_res = src_a ^ src_b;
      3'b111:  sc_res = WIDTH'(src_a < src_b);
      default: begin
        case (funct)
          6'b100000, 6'b100001: sc_res = src_a + src_b;
          6'b100010, 6'b100011: sc_res = src_a - src_b;
          6'b100100: sc_res = src_a & src_b;
          6'b100101: sc_res = src_a | src_b;
          6'b100110: sc_res = src_a ^ src_b;
          6'b100111: sc_res = ~(src_a | src_b);
          6'b101010: sc_res = WIDTH'(sa < sb);
          6'b101001: sc_res = WIDTH'(src_a < src_b);
          6'b001001: sc_res = src_a + src_b;
          6'b001000: sc_res = '0;
          6'b000000: sc_res = src_b << shamt;
          6'b000010: sc_res = src_b >> shamt;
          6'b000011: sc_res = sb >>> shamt;
          6'b000100: sc_res = src_b << vamt;
          6'b000110: sc_res = src_b >> vamt;
          6'b000111: sc_res = sb >>> vamt;
          6'b010000: sc_res = hi;
          6'b010010: sc_res = lo;
          6'b010001: begin
            sc_res = src_a;
            wr_hi  = 1'b1;
          end
          6'b010011: begin
            sc_res = src_a;
            wr_lo  = 1'b1;
          end
          6'b011000: begin
            go_mul    = 1'b1;
            md_signed = 1'b1;
          end
          6'b011001: go_mul = 1'b1;
          6'b011010: begin
            go_div    = 1'b1;
            md_signed = 1'b1;
          end
          6'b011011: go_div = 1'b1;
          default:   sc_ill = 1'b1;
        endcase
      end
    endcase
  end

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] md_p;
  logic [WIDTH-1:0]   md_cand, md_q, md_rem, md_a;
  logic               md_neg_q, md_neg_r, md_div0;
  logic               last;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod_fix;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem_next, div_q_next, div_lo, div_hi;

  assign busy  = (state != IDLE);
  assign last  = (cnt == CNT_W'(1));
  assign mag_a = magnitude(src_a, md_signed);
  assign mag_b = magnitude(src_b, md_signed);

  // One shift-add multiply step: the multiplier sits in the low half of md_p
  // and is consumed from bit 0 while partial products accumulate above it.
  assign mul_sum  = {1'b0, md_p[2*WIDTH-1:WIDTH]} + {1'b0, (md_p[0] ? md_cand : '0)};
  assign mul_next = {mul_sum, md_p[WIDTH-1:1]};
  assign prod_fix = apply_sign2(mul_next, md_neg_q);

  // One restoring-divide step: shift the next dividend bit into the partial
  // remainder and keep the subtraction only if it does not go negative.
  assign div_shift    = {md_rem, md_q[WIDTH-1]};
  assign div_ok       = (div_shift >= {1'b0, md_cand});
  assign div_rem_next = div_ok ? WIDTH'(div_shift - {1'b0, md_cand}) : div_shift[WIDTH-1:0];
  assign div_q_next   = {md_q[WIDTH-2:0], div_ok};
  assign div_lo       = md_div0 ? '1   : apply_sign(div_q_next, md_neg_q);
  assign div_hi       = md_div0 ? md_a : apply_sign(div_rem_next, md_neg_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: enter MUL/DIV on an accepted start, leave after the last step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && go_mul)      state_nxt = MUL;
        else if (start && go_div) state_nxt = DIV;
      end
      MUL, DIV: if (last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and HI/LO/result writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      md_p     <= '0;
      md_cand  <= '0;
      md_q     <= '0;
      md_rem   <= '0;
      md_a     <= '0;
      md_neg_q <= 1'b0;
      md_neg_r <= 1'b0;
      md_div0  <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (go_mul || go_div) begin
              cnt      <= CNT_W'(WIDTH);
              md_p     <= {{WIDTH{1'b0}}, mag_b};
              md_cand  <= go_div ? mag_b : mag_a;
              md_q     <= mag_a;
              md_rem   <= '0;
              md_a     <= src_a;
              md_neg_q <= md_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              md_neg_r <= md_signed & src_a[WIDTH-1];
              md_div0  <= (src_b == '0);
            end else begin
              result  <= sc_res;
              zero    <= (sc_res == '0);
              done    <= 1'b1;
              illegal <= sc_ill;
              if (wr_hi) hi <= src_a;
              if (wr_lo) lo <= src_a;
            end
          end
        end
        MUL: begin
          md_p <= mul_next;
          cnt  <= cnt - CNT_W'(1);
          if (last) begin
            hi     <= prod_fix[2*WIDTH-1:WIDTH];
            lo     <= prod_fix[WIDTH-1:0];
            result <= prod_fix[WIDTH-1:0];
            zero   <= (prod_fix[WIDTH-1:0] == '0);
            done   <= 1'b1;
          end
        end
        DIV: begin
          md_rem <= div_rem_next;
          md_q   <= div_q_next;
          cnt    <= cnt - CNT_W'(1);
          if (last) begin
            hi     <= div_hi;
            lo     <= div_lo;
            result <= div_lo;
            zero   <= (div_lo == '0);
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
